// File: rtl/post_add_out_stage.sv
// Output stage after the 48-bit post adder: optional P/carry pipeline registers,
// cascade and fabric copies, accumulator feedback, and zero/sticky-carry/count status.
module post_add_out_stage #(
   parameter int unsigned PREG        = 1,
   parameter int unsigned CARRYOUTREG = 1,
   parameter int unsigned CNTW        = 16
) (
   input  logic            CLK,
   input  logic            RSTP,
   input  logic            CEP,
   input  logic [47:0]     RESULT,
   input  logic            COUT,
   input  logic            VALID_IN,
   input  logic            CLR,
   output logic [47:0]     P,
   output logic [47:0]     PCOUT,
   output logic [47:0]     P_FB,
   output logic            CARRYOUT,
   output logic            CARRYOUTF,
   output logic            ZERO,
   output logic            VALID_OUT,
   output logic            STICKY_CY,
   output logic [CNTW-1:0] ACC_CNT
);

   localparam int unsigned      DW      = 48;
   localparam logic [CNTW-1:0]  CNT_MAX = {CNTW{1'b1}};

   logic [DW-1:0]   r_p;
   logic            r_cy;
   logic            r_zero;
   logic            r_valid;
   logic            r_sticky;
   logic [CNTW-1:0] r_cnt;

   logic            w_res_zero;
   logic            w_sticky_next;
   logic [CNTW-1:0] w_cnt_base;
   logic [CNTW-1:0] w_cnt_next;

   assign w_res_zero = (RESULT == '0);

   // Status next-state: a valid carry sets the sticky flag even on a clear cycle.
   always_comb begin
      w_sticky_next = (CLR ? 1'b0 : r_sticky) | (VALID_IN & COUT);
      w_cnt_base    = CLR ? '0 : r_cnt;
      w_cnt_next    = w_cnt_base;
      if (VALID_IN && (w_cnt_base != CNT_MAX)) begin
         w_cnt_next = w_cnt_base + CNTW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTP) begin
         r_p      <= '0;
         r_cy     <= 1'b0;
         r_zero   <= 1'b0;
         r_valid  <= 1'b0;
         r_sticky <= 1'b0;
         r_cnt    <= '0;
      end else if (CEP) begin
         r_p      <= RESULT;
         r_cy     <= COUT;
         r_zero   <= w_res_zero;
         r_valid  <= VALID_IN;
         r_sticky <= w_sticky_next;
         r_cnt    <= w_cnt_next;
      end
   end

   // Feedback always comes from the register so the accumulate loop stays broken.
   assign P_FB      = r_p;
   assign P         = (PREG != 0) ? r_p     : RESULT;
   assign PCOUT     = P;
   assign ZERO      = (PREG != 0) ? r_zero  : w_res_zero;
   assign VALID_OUT = (PREG != 0) ? r_valid : VALID_IN;
   assign CARRYOUT  = (CARRYOUTREG != 0) ? r_cy : COUT;
   assign CARRYOUTF = CARRYOUT;
   assign STICKY_CY = r_sticky;
   assign ACC_CNT   = r_cnt;

endmodule
